// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_MEM_WAIT = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_HALTED   = 3'd3,
    ST_ERROR    = 3'd4
  } state_e;

  localparam int DEF_MEM_TIMEOUT  = 15;
  localparam int DEF_DRAIN_CYCLES = 4;
  localparam int DEF_CNT_W        = 16;

endpackage

// File: rtl/stall_perf_counters.sv
// Saturating performance counters for stall, RUN-state flush and load-use events.
module stall_perf_counters #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_ev,
  input  logic             flush_ev,
  input  logic             lu_ev,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] lu_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      lu_cnt    <= '0;
    end else begin
      if (stall_ev && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_ev && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      if (lu_ev && lu_cnt != '1)       lu_cnt    <= lu_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer: merges load-use, data-memory handshake, branch redirect
// and halt into pipeline-register enables. STALL_PERF_EN adds saturating perf counters.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
`ifdef STALL_PERF_EN
  parameter int CNT_W        = DEF_CNT_W,
`endif
  parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lu_hazard,
  input  logic       branch_taken,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  input  logic       halt_req,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_mem_write,
  output logic       mem_wb_bubble,
  output logic       halted,
  output logic       mem_timeout,
  output logic [2:0] state
`ifdef STALL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] lu_cnt
`endif
);

  localparam logic [7:0] TO_LIMIT   = 8'(MEM_TIMEOUT);
  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  state_e     state_q, state_d;
  logic [7:0] to_cnt_q, to_cnt_d;
  logic [3:0] drain_cnt_q, drain_cnt_d;
  logic       ret_drain_q, ret_drain_d;
  logic       timeout_q, timeout_d;
  logic       mem_stall, freeze, run_eval, drain_eval;

  assign state       = state_q;
  assign mem_timeout = timeout_q;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_write  = 1'b1;
    mem_wb_bubble = 1'b0;
    halted        = 1'b0;
    freeze        = 1'b0;
    run_eval      = 1'b0;
    drain_eval    = 1'b0;
    state_d       = state_q;
    to_cnt_d      = to_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    ret_drain_d   = ret_drain_q;
    timeout_d     = timeout_q;
    mem_stall     = dmem_req && !dmem_ready &&
                    (state_q == ST_RUN || state_q == ST_DRAIN);

    // While reset is held the enables show the free-running RUN values regardless of inputs.
    if (!rst_n) begin
      freeze = 1'b0;
    end else if (mem_stall) begin
      freeze      = 1'b1;
      state_d     = ST_MEM_WAIT;
      to_cnt_d    = 8'd1;
      ret_drain_d = (state_q == ST_DRAIN);
    end else begin
      unique case (state_q)
        ST_RUN:   run_eval   = 1'b1;
        ST_DRAIN: drain_eval = 1'b1;
        ST_MEM_WAIT: begin
          if (dmem_ready) begin
            run_eval   = !ret_drain_q;
            drain_eval = ret_drain_q;
          end else begin
            freeze = 1'b1;
            if (to_cnt_q == TO_LIMIT) begin
              state_d   = ST_ERROR;
              timeout_d = 1'b1;
            end else begin
              to_cnt_d = to_cnt_q + 8'd1;
            end
          end
        end
        ST_HALTED: begin
          freeze = 1'b1;
          halted = 1'b1;
          if (!halt_req) state_d = ST_RUN;
        end
        default: freeze = 1'b1;
      endcase
    end

    if (run_eval) begin
      if (branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (lu_hazard) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
      state_d = halt_req ? ST_DRAIN : ST_RUN;
      if (halt_req) drain_cnt_d = DRAIN_INIT;
    end

    // Drain: fetch is gated off, but a redirect must still land in the PC.
    if (drain_eval) begin
      pc_write    = branch_taken;
      if_id_flush = 1'b1;
      state_d     = ST_DRAIN;
      if (lu_hazard) begin
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end else if (drain_cnt_q <= 4'd1) begin
        drain_cnt_d = 4'd0;
        state_d     = ST_HALTED;
      end else begin
        drain_cnt_d = drain_cnt_q - 4'd1;
      end
    end

    if (freeze) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      to_cnt_q    <= '0;
      drain_cnt_q <= '0;
      ret_drain_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      ret_drain_q <= ret_drain_d;
      timeout_q   <= timeout_d;
    end
  end

`ifdef STALL_PERF_EN
  logic stall_ev, flush_ev, lu_ev;

  assign stall_ev = !pc_write;
  assign flush_ev = run_eval && if_id_flush;
  assign lu_ev    = run_eval && lu_hazard && !branch_taken;

  stall_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall_ev  (stall_ev),
    .flush_ev  (flush_ev),
    .lu_ev     (lu_ev),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .lu_cnt    (lu_cnt)
  );
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: a behavioural model predicts each cycle's
// enables and state; a negedge monitor pops and compares.
module tb_pipeline_stall_ctrl;

  localparam int T_MEM_TIMEOUT = 15;
  localparam int T_DRAIN       = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lu_hazard = 1'b0, branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0, halt_req = 1'b0;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_bubble;
  logic halted, mem_timeout;
  logic [2:0] state;

  pipeline_stall_ctrl #(.MEM_TIMEOUT(T_MEM_TIMEOUT), .DRAIN_CYCLES(T_DRAIN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lu_hazard     (lu_hazard),
    .branch_taken  (branch_taken),
    .dmem_req      (dmem_req),
    .dmem_ready    (dmem_ready),
    .halt_req      (halt_req),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_write  (ex_mem_write),
    .mem_wb_bubble (mem_wb_bubble),
    .halted        (halted),
    .mem_timeout   (mem_timeout),
    .state         (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write, if_id_write, if_id_flush, id_ex_flush;
    logic       ex_mem_write, mem_wb_bubble, halted, mem_timeout;
    logic [2:0] state;
  } obs_t;

  typedef struct {
    obs_t  v;
    string name;
  } exp_t;

  exp_t exp_q[$];
  obs_t obs;
  int   checks = 0;
  int   errors = 0;

  assign obs = {pc_write, if_id_write, if_id_flush, id_ex_flush,
                ex_mem_write, mem_wb_bubble, halted, mem_timeout, state};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t it;
      it = exp_q.pop_front();
      check(it.name, 32'(obs), 32'(it.v));
    end
  end

  // Behavioural model: tracks what the pipeline is doing, not how the RTL encodes it.
  bit m_wait, m_draining, m_stopped, m_dead, m_tflag;
  int m_wait_n, m_drain_left;

  task automatic model_reset();
    m_wait = 0; m_draining = 0; m_stopped = 0; m_dead = 0; m_tflag = 0;
    m_wait_n = 0; m_drain_left = 0;
  endtask

  task automatic model_step(input string name);
    obs_t e;
    exp_t it;
    bit   frz;
    e = '0;
    e.pc_write = 1; e.if_id_write = 1; e.ex_mem_write = 1;
    frz = 0;
    e.state = m_dead ? 3'd4 : m_stopped ? 3'd3 : m_wait ? 3'd1 : m_draining ? 3'd2 : 3'd0;
    e.mem_timeout = m_tflag;
    if (m_dead) frz = 1;
    else if (m_stopped) begin
      frz = 1; e.halted = 1;
      if (!halt_req) m_stopped = 0;
    end else if (m_wait && !dmem_ready) begin
      frz = 1;
      if (m_wait_n == T_MEM_TIMEOUT) begin m_dead = 1; m_tflag = 1; end
      else m_wait_n++;
    end else if (!m_wait && dmem_req && !dmem_ready) begin
      frz = 1; m_wait = 1; m_wait_n = 1;
    end else begin
      m_wait = 0;
      if (m_draining) begin
        e.pc_write = branch_taken; e.if_id_flush = 1;
        if (lu_hazard) begin e.if_id_write = 0; e.id_ex_flush = 1; end
        else begin
          m_drain_left--;
          if (m_drain_left == 0) begin m_draining = 0; m_stopped = 1; end
        end
      end else begin
        if (branch_taken) begin e.if_id_flush = 1; e.id_ex_flush = 1; end
        else if (lu_hazard) begin e.pc_write = 0; e.if_id_write = 0; e.id_ex_flush = 1; end
        if (halt_req) begin m_draining = 1; m_drain_left = T_DRAIN; end
      end
    end
    if (frz) begin
      e.pc_write = 0; e.if_id_write = 0; e.ex_mem_write = 0; e.mem_wb_bubble = 1;
    end
    it.v = e;
    it.name = name;
    exp_q.push_back(it);
  endtask

  // Called at posedge+1; drives one cycle and returns at the next posedge+1.
  task automatic drive(input bit lu, input bit br, input bit req, input bit rdy,
                       input bit halt, input string name);
    lu_hazard = lu; branch_taken = br; dmem_req = req; dmem_ready = rdy; halt_req = halt;
    model_step(name);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string name);
    obs_t rv;
    rv = '0;
    rv.pc_write = 1; rv.if_id_write = 1; rv.ex_mem_write = 1;
    rst_n = 1'b0;
    #1;
    check({name, "_async"}, 32'(obs), 32'(rv));
    lu_hazard = 0; branch_taken = 0; dmem_req = 0; dmem_ready = 0; halt_req = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_seg(input int n, input int rdy_pct, input string nm);
    bit h;
    h = 0;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(99) < 6) h = !h;
      drive($urandom_range(99) < 20, $urandom_range(99) < 15, $urandom_range(99) < 35,
            $urandom_range(99) < rdy_pct, h, $sformatf("%s[%0d]", nm, i));
    end
    do_reset({nm, "_rst"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset("reset0");

    drive(1, 0, 0, 0, 0, "lu_stall");
    drive(0, 0, 0, 0, 0, "lu_after");
    drive(0, 1, 0, 0, 0, "branch_run");
    drive(1, 1, 0, 0, 0, "branch_over_lu");

    for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 0, $sformatf("mwait[%0d]", i));
    drive(0, 0, 1, 1, 0, "mwait_ready");
    drive(0, 0, 0, 0, 0, "mwait_back");

    for (int i = 0; i < 7; i++) drive(0, 0, 0, 0, 1, $sformatf("halt[%0d]", i));
    drive(0, 0, 0, 0, 0, "halt_release");
    drive(0, 0, 0, 0, 0, "halt_run");

    drive(0, 0, 0, 0, 1, "brd_enter");
    drive(0, 0, 0, 0, 1, "brd_d1");
    drive(0, 1, 0, 0, 1, "brd_d2_branch");
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, $sformatf("brd_tail[%0d]", i));
    drive(0, 0, 0, 0, 0, "brd_release");

    drive(0, 0, 0, 0, 1, "dlu_enter");
    drive(1, 0, 0, 0, 0, "dlu_hold");
    drive(0, 0, 1, 0, 0, "dmw_stall");
    drive(0, 0, 1, 0, 0, "dmw_wait");
    drive(0, 0, 1, 1, 0, "dmw_ready");
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, $sformatf("dmw_tail[%0d]", i));

    for (int i = 0; i < 18; i++) drive(0, 0, 1, 0, 0, $sformatf("tmo[%0d]", i));
    for (int i = 0; i < 3; i++) drive(1, 1, 1, 1, 1, $sformatf("tmo_sticky[%0d]", i));
    do_reset("tmo_rst");
    drive(0, 0, 0, 0, 0, "tmo_cleared");

    drive(0, 0, 1, 0, 0, "arst_stall");
    drive(0, 0, 1, 0, 0, "arst_wait");
    lu_hazard = 0; branch_taken = 0; dmem_req = 1; dmem_ready = 0; halt_req = 0;
    #2;
    do_reset("arst_mid_wait");
    drive(0, 0, 0, 0, 0, "arst_after");

    for (int s = 0; s < 4; s++) rand_seg(200, 70, $sformatf("rnd%0d", s));
    rand_seg(200, 15, "rnd_slowmem");

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
